// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter
//
// Write-port arbiter for the integer register file. It accepts writeback
// requests from three producers and grants at most one of them per cycle.
// The granted write is registered and drives the register file's single
// write port.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   req_valid_i  [2:0]  request valid: 0 = pipeline WB, 1 = mul/div, 2 = load/CSR
//   req_addr_i   [14:0] destination register of requester n at [5n+4:5n]
//   req_data_i   [95:0] write data of requester n at [32n+31:32n]
//   req_ready_o  [2:0]  one-hot combinational grant (transfer = valid & ready)
//   we_o         registered register-file write enable
//   waddr_o      [4:0]  registered register-file write address
//   wdata_o      [31:0] registered register-file write data
//   grant_o      [2:0]  registered copy of the previous cycle's grant
//   pend_mask_o  [31:0] registers with a write queued at an input or held
//                       in the output stage (combinational, for decode)
//
// Priority: urgent port 1, urgent port 2, port 0, port 1, port 2.
// Ports 1 and 2 become urgent after losing WAIT_MAX consecutive cycles
// while valid, which bounds their wait.

module regs_wb_arbiter #(
  parameter int WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid_i,
  input  logic [14:0] req_addr_i,
  input  logic [95:0] req_data_i,
  output logic [2:0]  req_ready_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic [2:0]  grant_o,
  output logic [31:0] pend_mask_o
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

  // Aging counters exist for ports 1 and 2 only; port 0 never ages.
  logic [WW-1:0] wait_cnt [1:2];
  logic [2:0]    urgent;
  logic          xfer;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data;

  assign urgent[0] = 1'b0;

  for (genvar gi = 1; gi <= 2; gi++) begin : g_age
    assign urgent[gi] = req_valid_i[gi] && (wait_cnt[gi] == WAIT_LIM);

    // Count only while valid and losing; any grant or dropped valid
    // forgets the accumulated age.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wait_cnt[gi] <= '0;
      end else if (req_valid_i[gi] && !req_ready_o[gi]) begin
        if (wait_cnt[gi] != WAIT_LIM) begin
          wait_cnt[gi] <= wait_cnt[gi] + WW'(1);
        end
      end else begin
        wait_cnt[gi] <= '0;
      end
    end
  end

  // Grant is forced low while reset is held so no requester is released
  // by a write that would be discarded anyway.
  always_comb begin
    req_ready_o = 3'b000;
    if (!rst) begin
      req_ready_o = 3'b000;
    end else if (urgent[1]) begin
      req_ready_o = 3'b010;
    end else if (urgent[2]) begin
      req_ready_o = 3'b100;
    end else if (req_valid_i[0]) begin
      req_ready_o = 3'b001;
    end else if (req_valid_i[1]) begin
      req_ready_o = 3'b010;
    end else if (req_valid_i[2]) begin
      req_ready_o = 3'b100;
    end
  end

  assign xfer = |req_ready_o;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int n = 0; n < 3; n++) begin
      if (req_ready_o[n]) begin
        sel_addr = req_addr_i[5*n +: 5];
        sel_data = req_data_i[32*n +: 32];
      end
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      grant_o <= '0;
    end else begin
      we_o    <= xfer && (sel_addr != 5'd0);
      grant_o <= req_ready_o;
      if (xfer) begin
        waddr_o <= sel_addr;
        wdata_o <= sel_data;
      end
    end
  end

  always_comb begin
    pend_mask_o = '0;
    for (int n = 0; n < 3; n++) begin
      if (req_valid_i[n]) begin
        pend_mask_o[req_addr_i[5*n +: 5]] = 1'b1;
      end
    end
    if (we_o) begin
      pend_mask_o[waddr_o] = 1'b1;
    end
    pend_mask_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter
//
// Self-checking bench for regs_wb_arbiter. Directed reset / fixed-priority
// and pending-mask / mid-flight reset sequences bracket a randomized run.
// During the random run the stimulus process pushes expected values from a
// behavioural model into two queues; independent monitors pop and compare
// the combinational outputs (before the edge) and the registered outputs
// (after the edge).

module tb_regs_wb_arbiter;

  localparam int WAIT_MAX = 4;
  localparam int NCYC = 800;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid_i;
  logic [14:0] req_addr_i;
  logic [95:0] req_data_i;
  logic [2:0]  req_ready_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [2:0]  grant_o;
  logic [31:0] pend_mask_o;

  regs_wb_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .grant_o     (grant_o),
    .pend_mask_o (pend_mask_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  ready;
    logic [31:0] pend;
  } comb_exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  grant;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  // Requester state and reference model state
  logic        pv [3];
  logic [4:0]  pa [3];
  logic [31:0] pd [3];
  int          age [3];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  // Combinational monitor: inputs change at negedge, compare 2 units later.
  always @(negedge clk) begin
    comb_exp_t ce;
    #2;
    if (comb_q.size() > 0) begin
      ce = comb_q.pop_front();
      check("req_ready", 32'(req_ready_o), 32'(ce.ready));
      check("pend_mask", pend_mask_o, ce.pend);
    end
  end

  // Registered monitor: compare 1 unit after the active edge.
  always @(posedge clk) begin
    reg_exp_t re;
    #1;
    if (reg_q.size() > 0) begin
      re = reg_q.pop_front();
      check("we", 32'(we_o), 32'(re.we));
      check("waddr", 32'(waddr_o), 32'(re.waddr));
      check("wdata", wdata_o, re.wdata);
      check("grant", 32'(grant_o), 32'(re.grant));
      if (re.grant != 3'b000)
        $display("txn grant=%b we=%b waddr=%0d wdata=%h", re.grant, re.we, re.waddr, re.wdata);
    end
  end

  task automatic drive_inputs();
    for (int n = 0; n < 3; n++) begin
      req_valid_i[n]        = pv[n];
      req_addr_i[5*n +: 5]  = pa[n];
      req_data_i[32*n +: 32] = pd[n];
    end
  endtask

  initial begin
    int g;
    int p0;
    logic [2:0]  exp_ready;
    logic [31:0] exp_pend;

    // ---------------- reset with all ports valid ----------------
    rst = 1'b0;
    pv[0] = 1'b1; pa[0] = 5'd5; pd[0] = 32'h11;
    pv[1] = 1'b1; pa[1] = 5'd6; pd[1] = 32'h22;
    pv[2] = 1'b1; pa[2] = 5'd7; pd[2] = 32'h33;
    drive_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready_o), 32'h0);
    check("rst_we", 32'(we_o), 32'h0);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_waddr", 32'(waddr_o), 32'h0);
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_pend", pend_mask_o, 32'h0000_00E0);

    // ---------------- fixed priority after release ----------------
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("first_grant", 32'(req_ready_o), 32'h1);
    @(posedge clk); #1;
    check("fp0_we", 32'(we_o), 32'h1);
    check("fp0_waddr", 32'(waddr_o), 32'd5);
    check("fp0_wdata", wdata_o, 32'h11);
    @(negedge clk);
    pv[0] = 1'b0; drive_inputs();
    #1;
    check("fp1_ready", 32'(req_ready_o), 32'h2);
    @(posedge clk); #1;
    check("fp1_waddr", 32'(waddr_o), 32'd6);
    check("fp1_wdata", wdata_o, 32'h22);
    check("fp1_grant", 32'(grant_o), 32'h2);
    @(negedge clk);
    pv[1] = 1'b0; drive_inputs();
    #1;
    check("fp2_ready", 32'(req_ready_o), 32'h4);
    @(posedge clk); #1;
    check("fp2_we", 32'(we_o), 32'h1);
    check("fp2_waddr", 32'(waddr_o), 32'd7);
    check("fp2_wdata", wdata_o, 32'h33);
    pv[2] = 1'b0;

    // Model state matching the end of the directed sequence
    age[0] = 0; age[1] = 0; age[2] = 0;
    m_we = 1'b1; m_waddr = 5'd7; m_wdata = 32'h33;

    // ---------------- randomized run with scoreboard ----------------
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Alternate between port-0 flood windows and lighter traffic so
      // aging and double urgency are exercised.
      p0 = ((cyc / 100) % 2 == 0) ? 95 : 40;
      for (int n = 0; n < 3; n++) begin
        if (!pv[n]) begin
          if ($urandom_range(0, 99) < ((n == 0) ? p0 : 30)) begin
            pv[n] = 1'b1;
            pa[n] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                  : 5'($urandom_range(0, 31));
            pd[n] = $urandom;
          end
        end else if (n != 0 && $urandom_range(0, 99) < 3) begin
          pv[n] = 1'b0;   // withdraw before grant: age must be forgotten
        end
      end
      drive_inputs();

      // Pending mask: queued inputs plus the current output stage.
      exp_pend = '0;
      for (int n = 0; n < 3; n++)
        if (pv[n]) exp_pend[pa[n]] = 1'b1;
      if (m_we) exp_pend[m_waddr] = 1'b1;
      exp_pend[0] = 1'b0;

      // Priority rule, first match wins.
      if (pv[1] && age[1] == WAIT_MAX)      g = 1;
      else if (pv[2] && age[2] == WAIT_MAX) g = 2;
      else if (pv[0])                       g = 0;
      else if (pv[1])                       g = 1;
      else if (pv[2])                       g = 2;
      else                                  g = -1;
      exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      comb_q.push_back('{exp_ready, exp_pend});

      for (int n = 1; n < 3; n++) begin
        if (pv[n] && g != n) begin
          if (age[n] < WAIT_MAX) age[n]++;
        end else begin
          age[n] = 0;
        end
      end

      if (g >= 0) begin
        m_we    = (pa[g] != 5'd0);
        m_waddr = pa[g];
        m_wdata = pd[g];
        pv[g]   = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      reg_q.push_back('{m_we, m_waddr, m_wdata, exp_ready});
    end
    @(posedge clk); #3;
    check("queues_drained", 32'(comb_q.size() + reg_q.size()), 32'h0);

    // ---------------- pending mask and reset mid-flight ----------------
    @(negedge clk);
    pv[0] = 1'b0; pv[1] = 1'b0; pv[2] = 1'b0;
    drive_inputs();
    @(negedge clk);
    pv[0] = 1'b1; pa[0] = 5'd3;  pd[0] = 32'hA5A5_0003;
    pv[1] = 1'b1; pa[1] = 5'd12; pd[1] = 32'h0000_DEAD;
    drive_inputs();
    #1;
    check("pm_ready0", 32'(req_ready_o), 32'h1);
    check("pm_pend0", pend_mask_o, 32'h0000_1008);
    @(negedge clk);
    pv[0] = 1'b0; drive_inputs();
    #1;
    check("pm_ready1", 32'(req_ready_o), 32'h2);
    check("pm_pend1", pend_mask_o, 32'h0000_1008);
    @(posedge clk); #1;
    check("pm_we", 32'(we_o), 32'h1);
    check("pm_waddr", 32'(waddr_o), 32'd12);
    @(negedge clk);
    pv[1] = 1'b0; drive_inputs();
    #1;
    check("pm_pend_out", pend_mask_o, 32'h0000_1000);
    rst = 1'b0;
    #1;
    check("mid_rst_we", 32'(we_o), 32'h0);
    check("mid_rst_pend", pend_mask_o, 32'h0);
    pv[2] = 1'b1; pa[2] = 5'd9; drive_inputs();
    #1;
    check("mid_rst_ready", 32'(req_ready_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_wb_arbiter.md
# regs_wb_arbiter

Write-port arbiter for the integer register file. It accepts writeback requests from three producers: pipeline writeback, the multi-cycle mul/div unit, and the load/CSR return path. Each cycle it grants at most one request, under fixed priority with an aging override so no producer starves. The granted write is registered and drives the register file's single write port. It also exports a pending-write mask that decode uses for hazard stalls.

## Interface
- `WAIT_MAX`, 4: cycles a valid port 1/2 request may lose before it becomes urgent; legal 1..15.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`RstEnable` = 0).
- `req_valid_i`  in  3  bit n = requester n has a write; 0 = pipeline WB, 1 = mul/div, 2 = load/CSR.
- `req_addr_i`  in  15  requester n destination at [5n+4:5n].
- `req_data_i`  in  96  requester n data at [32n+31:32n].
- `req_ready_o`  out  3  one-hot grant; a transfer occurs when valid & ready.
- `we_o`  out  1  register-file write enable, registered.
- `waddr_o`  out  5  register-file write address, registered.
- `wdata_o`  out  32  register-file write data, registered.
- `grant_o`  out  3  registered copy of the last cycle's grant, for debug and perf counters.
- `pend_mask_o`  out  32  bit r set while register r has an unwritten write, either queued at an input or held in the output stage.

## Operation
- Grant is computed combinationally from `req_valid_i` and the aging state. At most one bit of `req_ready_o` is set, and only for a valid port.
- Each of ports 1 and 2 has an aging counter `wait_n` with width $clog2(WAIT_MAX+1).
  - Increment when valid and not granted; saturate at `WAIT_MAX`.
  - Clear to 0 on grant, or when valid is low.
- Port n is urgent when `wait_n == WAIT_MAX`.
- Priority, first match wins:
  - urgent port 1
  - urgent port 2
  - port 0
  - port 1
  - port 2
- Output stage on a transfer:
  - Register `we_o` = (addr != 0), `waddr_o` = addr, `wdata_o` = data, `grant_o` = `req_ready_o`.
  - With no transfer, `we_o` goes to 0. `waddr_o` and `wdata_o` hold their previous values.
- Writes to x0 are accepted (ready asserted, requester released) but dropped: `we_o` = 0.
- `pend_mask_o` is combinational: OR of onehot(addr) over all valid inputs, plus onehot(`waddr_o`) when `we_o`=1. Bit 0 is always 0.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not check this.
- No downstream backpressure exists; the register file accepts every cycle.

## Timing
- Reset values:
  - `we_o`=0, `waddr_o`=0, `wdata_o`=0, `grant_o`=0, `wait_1`=`wait_2`=0.
  - `req_ready_o`=0 while `rst`=0, forced regardless of valid.
  - `pend_mask_o` reflects inputs only.
- Latency:
  - Request accepted at edge k: `we_o`/`waddr_o`/`wdata_o` valid in cycle k..k+1.
  - The register file commits at edge k+1.
  - The register-file read bypass makes the value visible to readers during cycle k..k+1.
- Throughput: one write per cycle, sustained.
- Worst-case wait for port 1: `WAIT_MAX` cycles.
- Worst-case wait for port 2: `WAIT_MAX`+1 cycles; it loses only to an urgent port 1, which is then cleared.
- Simultaneous events:
  - Two ports targeting the same register are serialized in priority order, so the later grant overwrites.
  - A port whose valid drops before grant loses its age; no stale urgency is kept.
- Reset mid-operation:
  - An in-flight output write is discarded: `we_o` clears asynchronously and the register file sees no write.
  - Ungranted requests are neither lost nor accepted; requesters retry after reset.
- `pend_mask_o` must not add a register stage; decode samples it in the same cycle.

## Test plan
- Reset: assert `rst`=0 with all ports valid → `req_ready_o`=000, `we_o`=0, `wdata_o`=0. Release → the first grant is port 0.
- Fixed priority: ports 0/1/2 valid to x5/x6/x7 with data 0x11/0x22/0x33, port 0 dropping after accept → grants 001, 010, 100 on consecutive cycles. `we_o`=1 for three cycles with `waddr_o` 5, 6, 7.
- Aging, `WAIT_MAX`=4: port 0 valid every cycle with new data; port 1 valid to x9, data 0xDEAD → port 1 granted on the 5th cycle of waiting. Port 0 stalls exactly that one cycle.
- Double urgency: ports 1 and 2 both reach `WAIT_MAX` under port-0 flood → port 1 granted, then port 2 the next cycle, then port 0 resumes.
- x0 drop: port 2 valid to x0 with data 0xFFFFFFFF → `req_ready_o`=100, `grant_o`=100 next cycle, `we_o`=0. `pend_mask_o` bit 0 stays 0.
- Pending mask and reset mid-flight: port 1 valid to x12 while port 0 wins → bit 12 set. After grant, bit 12 stays set for one more cycle (output stage). Asserting `rst` that cycle clears `we_o` immediately.
